// File: rtl/fetch_unit.sv
// Instruction fetch stage: a 64-bit PC drives a combinational instruction memory,
// and fetched {pc, instr} pairs are buffered in a 2-entry in-order queue for decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [63:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;

  logic [63:0] slot_pc_q    [2];
  logic [31:0] slot_instr_q [2];

  logic empty, full, enq, deq;

  // A redirect always lands on a word boundary, so the low target bits are ignored.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  assign imem_addr = pc_q;

  always_comb begin
    empty    = (count_q == 2'd0);
    full     = (count_q == 2'd2);
    enq      = !full && !branch_taken;
    id_valid = !empty && !branch_taken;
    deq      = id_valid && id_ready;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    id_instr = NOP_INSTR;
    id_pc    = 64'h0;
    if (!empty) begin
      id_instr = slot_instr_q[head_q];
      id_pc    = slot_pc_q[head_q];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (branch_taken) begin
      pc_d    = {branch_target[63:2], 2'b00};
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (enq) begin
        pc_d   = pc_q + 64'd4;
        tail_d = tail_q + 1'b1;
      end
      if (deq) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; a zero count makes its contents unobservable.
  always_ff @(posedge clk) begin
    if (enq) begin
      slot_pc_q[tail_q]    <= pc_q;
      slot_instr_q[tail_q] <= imem_rdata;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter: RESET_PC, 64'h0, PC loaded on reset.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port: imem_addr  output  64  fetch address to Instruction_memory (combinational read).
REQ-005 SHALL provide port: imem_rdata  input  32  instruction word returned for imem_addr in the same cycle.
REQ-006 SHALL provide port: branch_taken  input  1  redirect request from execute (Branch & Zero).
REQ-007 SHALL provide port: branch_target  input  64  redirect PC (PC + imm<<1).
REQ-008 SHALL provide port: id_ready  input  1  decode accepts the head instruction this cycle.
REQ-009 SHALL provide port: id_valid  output  1  head entry valid for decode.
REQ-010 SHALL provide port: id_instr  output  32  head instruction word.
REQ-011 SHALL provide port: id_pc  output  64  PC of head instruction.

Function
REQ-012 SHALL hold a 64-bit PC register; imem_addr SHALL equal PC combinationally.
REQ-013 SHALL hold a 2-entry in-order queue of {pc, instr} with head/tail pointers and a 2-bit count (0..2).
REQ-014 Enqueue SHALL occur when count<2 and branch_taken=0: push {PC, imem_rdata} at tail; PC <= PC+4.
REQ-015 When count==2, no enqueue SHALL occur and PC SHALL hold, even if a dequeue happens the same cycle.
REQ-016 id_valid SHALL be (count!=0) & ~branch_taken; id_instr/id_pc SHALL show the head entry.
REQ-017 When count==0, id_instr SHALL read 32'h00000013 (NOP) and id_pc SHALL read 64'h0.
REQ-018 Dequeue SHALL occur when id_valid & id_ready; the head pointer advances and count decrements.
REQ-019 Simultaneous enqueue and dequeue SHALL leave count unchanged; order SHALL be preserved.
REQ-020 Latency: a word enqueued at edge N SHALL be visible on id_* in the cycle after edge N; steady state SHALL sustain one instruction per cycle with id_ready=1.
REQ-021 branch_taken=1 SHALL, at the edge, clear count and pointers, drop any enqueue/dequeue that cycle, and load PC <= {branch_target[63:2], 2'b00}.
REQ-022 PC increment SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
REQ-023 Pointer increments SHALL wrap 1 -> 0.
REQ-024 id_ready while id_valid=0 SHALL have no effect.

Reset
REQ-025 reset=1 at an edge SHALL set PC=RESET_PC, count=0, pointers=0, taking priority over branch_taken and all handshakes.
REQ-026 During and directly after reset: id_valid=0, id_instr=32'h00000013, id_pc=0, imem_addr=RESET_PC.
REQ-027 Queue storage contents SHALL need no reset; they are unobservable while count==0.

Verification
REQ-028 Reset start: reset 2 cycles, then id_ready=1, imem returns mem[addr] -> imem_addr 0,4,8,... each cycle; id_pc 0,4,8 starting one cycle after release; id_valid=1 from then on.
REQ-029 Backpressure: id_ready=0 for 5 cycles from reset release -> count reaches 2 holding PC 0,4; imem_addr stalls at 8; then id_ready=1 -> id_pc 0,4,8,C in order, no loss or duplicate.
REQ-030 Redirect with full queue: branch_taken=1, target 0x100 -> id_valid=0 that cycle; next cycle count=0, imem_addr=0x100; following cycle id_pc=0x100.
REQ-031 Unaligned redirect: target 0x103 -> imem_addr=0x100 next cycle.
REQ-032 Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, id_ready=1 -> imem_addr FFFC then 0x0; id_pc sequence FFFC, 0x0.
REQ-033 Reset mid-operation: count=2 and branch_taken=1 with reset=1 same edge -> PC=RESET_PC, count=0, id_valid=0 next cycle.
